// File: rtl/vibrate_dect_pkg.sv
// Shared definitions for the vibration detector: data width, the detector FSM
// encoding and the two's-complement to offset-binary conversion.
package vibrate_dect_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    PVD_IDLE  = 2'd0,
    PVD_FIRST = 2'd1,
    PVD_ACCUM = 2'd2
  } pvd_state_e;

  // Inverting the MSB maps two's complement onto offset binary, so that
  // plain unsigned compares order the samples correctly.
  function automatic logic [DATA_W-1:0] to_offset_bin(input logic [DATA_W-1:0] data,
                                                      input logic              twos);
    return twos ? {~data[DATA_W-1], data[DATA_W-2:0]} : data;
  endfunction

endpackage

// File: rtl/minmax_track.sv
// Running maximum/minimum registers with load/update controls; the
// combinational next values let the emit path include the current sample.
module minmax_track
  import vibrate_dect_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              update,
  input  logic [DATA_W-1:0] s,
  output logic [DATA_W-1:0] next_max,
  output logic [DATA_W-1:0] next_min
);

  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] min_q;

  // Strict compares: a tie keeps the stored value.
  assign next_max = (s > max_q) ? s : max_q;
  assign next_min = (s < min_q) ? s : min_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      min_q <= '0;
    end else if (load) begin
      max_q <= s;
      min_q <= s;
    end else if (update) begin
      max_q <= next_max;
      min_q <= next_min;
    end
  end

endmodule

// File: rtl/peak_valley_detect.sv
// Per-channel windowed peak/valley detector: tracks max/min over WIN_LEN
// accepted samples and emits them with a one-cycle strobe per window.
module peak_valley_detect
  import vibrate_dect_pkg::*;
#(
  parameter logic [15:0] WIN_LEN = 16'd1024,
  parameter logic        TWOS_IN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              det_en,
  input  logic [DATA_W-1:0] samp_data,
  input  logic              samp_en,
  output logic [DATA_W-1:0] Ch0_PData_ads2,
  output logic              Ch0_PData_en_ads2,
  output logic [DATA_W-1:0] Ch0_VData_ads2,
  output logic              Ch0_VData_en_ads2,
  output logic              win_busy,
  output logic [15:0]       win_cnt,
  output logic [1:0]        dbg_state
);

  if (WIN_LEN == 16'd0) begin : g_bad_win_len
    $error("peak_valley_detect: WIN_LEN must be in 1..65535");
  end

  localparam logic [15:0] LAST_CNT = WIN_LEN - 16'd1;

  pvd_state_e        state, state_n;
  logic [15:0]       cnt, cnt_n;
  logic [DATA_W-1:0] s;
  logic              load, update, emit;
  logic [DATA_W-1:0] emit_p, emit_v;
  logic [DATA_W-1:0] next_max, next_min;
  logic              pv_en;

  assign s = to_offset_bin(samp_data, TWOS_IN);

  minmax_track u_track (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .update   (update),
    .s        (s),
    .next_max (next_max),
    .next_min (next_min)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    update  = 1'b0;
    emit    = 1'b0;
    emit_p  = next_max;
    emit_v  = next_min;
    case (state)
      PVD_IDLE: begin
        cnt_n = '0;
        if (det_en) state_n = PVD_FIRST;
      end
      PVD_FIRST: begin
        if (!det_en) begin
          state_n = PVD_IDLE;
          cnt_n   = '0;
        end else if (samp_en) begin
          load = 1'b1;
          if (WIN_LEN == 16'd1) begin
            emit   = 1'b1;
            emit_p = s;
            emit_v = s;
            cnt_n  = '0;
          end else begin
            cnt_n   = 16'd1;
            state_n = PVD_ACCUM;
          end
        end
      end
      PVD_ACCUM: begin
        if (!det_en) begin
          state_n = PVD_IDLE;
          cnt_n   = '0;
        end else if (samp_en) begin
          update = 1'b1;
          if (cnt == LAST_CNT) begin
            // Final sample is folded in combinationally so no cycle is lost.
            emit    = 1'b1;
            cnt_n   = '0;
            state_n = PVD_FIRST;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end
      end
      default: begin
        state_n = PVD_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= PVD_IDLE;
      cnt            <= '0;
      pv_en          <= 1'b0;
      Ch0_PData_ads2 <= '0;
      Ch0_VData_ads2 <= '0;
      win_cnt        <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pv_en <= emit;
      if (emit) begin
        Ch0_PData_ads2 <= emit_p;
        Ch0_VData_ads2 <= emit_v;
        win_cnt        <= win_cnt + 16'd1;
      end
    end
  end

  assign Ch0_PData_en_ads2 = pv_en;
  assign Ch0_VData_en_ads2 = pv_en;
  assign win_busy          = (state == PVD_ACCUM);
  assign dbg_state         = state;

endmodule

// File: tb/tb_peak_valley_detect.sv
// Directed bench for peak_valley_detect: four parameterisations share one
// input stream; each scenario resets and checks the instance it targets.
module tb_peak_valley_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        det_en = 1'b0;
  logic [15:0] samp_data = '0;
  logic        samp_en = 1'b0;

  logic [15:0] p4, v4, c4, p2, v2, c2, p3, v3, c3, p1, v1, c1;
  logic        pe4, ve4, b4, pe2, ve2, b2, pe3, ve3, b3, pe1, ve1, b1;
  logic [1:0]  st4, st2, st3, st1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  peak_valley_detect #(.WIN_LEN(16'd4), .TWOS_IN(1'b0)) u4 (
    .clk(clk), .rst(rst), .det_en(det_en), .samp_data(samp_data), .samp_en(samp_en),
    .Ch0_PData_ads2(p4), .Ch0_PData_en_ads2(pe4), .Ch0_VData_ads2(v4),
    .Ch0_VData_en_ads2(ve4), .win_busy(b4), .win_cnt(c4), .dbg_state(st4));

  peak_valley_detect #(.WIN_LEN(16'd2), .TWOS_IN(1'b1)) u2 (
    .clk(clk), .rst(rst), .det_en(det_en), .samp_data(samp_data), .samp_en(samp_en),
    .Ch0_PData_ads2(p2), .Ch0_PData_en_ads2(pe2), .Ch0_VData_ads2(v2),
    .Ch0_VData_en_ads2(ve2), .win_busy(b2), .win_cnt(c2), .dbg_state(st2));

  peak_valley_detect #(.WIN_LEN(16'd3), .TWOS_IN(1'b0)) u3 (
    .clk(clk), .rst(rst), .det_en(det_en), .samp_data(samp_data), .samp_en(samp_en),
    .Ch0_PData_ads2(p3), .Ch0_PData_en_ads2(pe3), .Ch0_VData_ads2(v3),
    .Ch0_VData_en_ads2(ve3), .win_busy(b3), .win_cnt(c3), .dbg_state(st3));

  peak_valley_detect #(.WIN_LEN(16'd1), .TWOS_IN(1'b0)) u1 (
    .clk(clk), .rst(rst), .det_en(det_en), .samp_data(samp_data), .samp_en(samp_en),
    .Ch0_PData_ads2(p1), .Ch0_PData_en_ads2(pe1), .Ch0_VData_ads2(v1),
    .Ch0_VData_en_ads2(ve1), .win_busy(b1), .win_cnt(c1), .dbg_state(st1));

  typedef struct {
    logic        en;
    logic [15:0] d;
    logic        stb;
    logic [15:0] p;
    logic [15:0] v;
    logic [15:0] cnt;
    logic        busy;
  } vec_t;

  vec_t vt[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; det_en = 1'b0; samp_en = 1'b0; samp_data = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic feed(input logic en, input logic [15:0] d);
    samp_en = en; samp_data = d;
    step();
  endtask

  function automatic vec_t mk(input logic en, input logic [15:0] d, input logic stb,
                              input logic [15:0] p, input logic [15:0] v,
                              input logic [15:0] cnt, input logic busy);
    vec_t r;
    r.en = en; r.d = d; r.stb = stb; r.p = p; r.v = v; r.cnt = cnt; r.busy = busy;
    return r;
  endfunction

  initial begin
    // Record 0 lands in IDLE and must be ignored; later windows prove it.
    vt[0]  = mk(1, 16'd999,  0, 0,   0,  0, 0);
    vt[1]  = mk(1, 16'd100,  0, 0,   0,  0, 1);
    vt[2]  = mk(1, 16'd300,  0, 0,   0,  0, 1);
    vt[3]  = mk(1, 16'd50,   0, 0,   0,  0, 1);
    vt[4]  = mk(1, 16'd200,  1, 300, 50, 1, 0);
    vt[5]  = mk(0, 16'd0,    0, 300, 50, 1, 0);
    vt[6]  = mk(1, 16'd7,    0, 300, 50, 1, 1);
    vt[7]  = mk(1, 16'd7,    0, 300, 50, 1, 1);
    vt[8]  = mk(1, 16'd7,    0, 300, 50, 1, 1);
    vt[9]  = mk(1, 16'd8,    1, 8,   7,  2, 0);
    vt[10] = mk(1, 16'd1000, 0, 8,   7,  2, 1);
    vt[11] = mk(0, 16'd0,    0, 8,   7,  2, 1);

    // Reset state
    do_reset();
    chk("rst_p", p4, 0); chk("rst_v", v4, 0); chk("rst_stb", pe4, 0);
    chk("rst_cnt", c4, 0); chk("rst_busy", b4, 0); chk("rst_state", st4, 0);

    // Table: WIN_LEN=4, offset binary input
    det_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      feed(vt[i].en, vt[i].d);
      chk($sformatf("t%0d_pstb", i), pe4, vt[i].stb);
      chk($sformatf("t%0d_vstb", i), ve4, vt[i].stb);
      chk($sformatf("t%0d_p", i), p4, vt[i].p);
      chk($sformatf("t%0d_v", i), v4, vt[i].v);
      chk($sformatf("t%0d_cnt", i), c4, vt[i].cnt);
      chk($sformatf("t%0d_busy", i), b4, vt[i].busy);
    end

    // Two's complement input, WIN_LEN=2: -1 and +1
    do_reset();
    det_en = 1'b1;
    feed(0, 0);
    feed(1, 16'hFFFF);
    chk("tc_busy", b2, 1);
    feed(1, 16'h0001);
    chk("tc_stb", pe2, 1);
    chk("tc_p", p2, 16'h8001);
    chk("tc_v", v2, 16'h7FFF);
    chk("tc_diff", p2 - v2, 2);
    feed(0, 0);
    chk("tc_stb_off", pe2, 0);

    // Back-to-back windows, WIN_LEN=3, next window starts during the strobe
    do_reset();
    det_en = 1'b1;
    feed(0, 0);
    feed(1, 16'd5); feed(1, 16'd9); feed(1, 16'd1);
    chk("b2b_stb1", pe3, 1); chk("b2b_p1", p3, 9); chk("b2b_v1", v3, 1); chk("b2b_c1", c3, 1);
    feed(1, 16'd7);
    chk("b2b_stb_gap", pe3, 0); chk("b2b_busy", b3, 1);
    feed(1, 16'd7); feed(1, 16'd7);
    chk("b2b_stb2", pe3, 1); chk("b2b_p2", p3, 7); chk("b2b_v2", v3, 7); chk("b2b_c2", c3, 2);
    feed(0, 0);

    // det_en dropped mid-window, WIN_LEN=4
    do_reset();
    det_en = 1'b1;
    feed(0, 0);
    feed(1, 16'd11); feed(1, 16'd12);
    chk("ab_busy", b4, 1);
    det_en = 1'b0;
    feed(0, 0);
    chk("ab_stb", pe4, 0); chk("ab_busy_off", b4, 0); chk("ab_cnt", c4, 0); chk("ab_state", st4, 0);
    det_en = 1'b1;
    feed(0, 0);
    feed(1, 16'd10); chk("ab_nostb_a", pe4, 0);
    feed(1, 16'd20); chk("ab_nostb_b", pe4, 0);
    feed(1, 16'd30); chk("ab_nostb_c", pe4, 0);
    feed(1, 16'd40);
    chk("ab_stb2", pe4, 1); chk("ab_p", p4, 40); chk("ab_v", v4, 10); chk("ab_c", c4, 1);
    feed(0, 0);

    // rst pulsed mid-window after a prior emit
    do_reset();
    det_en = 1'b1;
    feed(0, 0);
    feed(1, 16'd1); feed(1, 16'd2); feed(1, 16'd3); feed(1, 16'd4);
    chk("mr_pre_c", c4, 1); chk("mr_pre_p", p4, 4);
    feed(1, 16'd5); feed(1, 16'd6);
    rst = 1'b1;
    feed(1, 16'd7);
    chk("mr_p", p4, 0); chk("mr_v", v4, 0); chk("mr_stb", pe4, 0);
    chk("mr_c", c4, 0); chk("mr_busy", b4, 0);
    rst = 1'b0;
    feed(0, 0);
    feed(1, 16'd9); chk("mr_nostb_a", pe4, 0);
    feed(1, 16'd8); chk("mr_nostb_b", pe4, 0);
    feed(1, 16'd6); chk("mr_nostb_c", pe4, 0);
    feed(1, 16'd3);
    chk("mr_stb2", pe4, 1); chk("mr_p2", p4, 9); chk("mr_v2", v4, 3); chk("mr_c2", c4, 1);
    feed(0, 0);

    // WIN_LEN=1: every sample emits; win_cnt wraps after 65536 windows
    do_reset();
    det_en = 1'b1;
    feed(0, 0);
    feed(1, 16'h1234);
    chk("w1_stb", pe1, 1); chk("w1_p", p1, 16'h1234); chk("w1_v", v1, 16'h1234);
    chk("w1_c", c1, 1); chk("w1_busy", b1, 0);
    feed(1, 16'h0010);
    chk("w1_stb2", pe1, 1); chk("w1_p2", p1, 16'h0010); chk("w1_c2", c1, 2);
    for (int i = 2; i < 65535; i++) begin
      samp_en = 1'b1; samp_data = 16'(i);
      @(posedge clk);
    end
    #1;
    chk("w1_c_ffff", c1, 16'hFFFF);
    feed(1, 16'hABCD);
    chk("w1_c_wrap", c1, 16'h0000);
    chk("w1_stb_wrap", pe1, 1);
    chk("w1_p_wrap", p1, 16'hABCD);
    chk("w1_v_wrap", v1, 16'hABCD);
    feed(0, 0);
    chk("w1_stb_off", pe1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
